// File: rtl/sockit_ghrd_button_irq_sequencer.sv
// Button PIO interrupt servicer: an Avalon-MM master that snapshots edge/level state into an event FIFO.
// Optional macro BTN_SEQ_TIMESTAMP_EN adds a 16-bit timestamp field to every event record.
module sockit_ghrd_button_irq_sequencer #(
    parameter logic [3:0]   IRQ_MASK   = 4'hF,
    parameter int unsigned  FIFO_DEPTH = 8,
    localparam int unsigned IDX_W      = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W      = IDX_W + 1,
`ifdef BTN_SEQ_TIMESTAMP_EN
    localparam int unsigned EVT_W      = 24
`else
    localparam int unsigned EVT_W      = 8
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             pio_irq,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [EVT_W-1:0] evt_data,
    output logic [CNT_W-1:0] evt_count,
    output logic             ovf,
    input  logic             ovf_clr
);

    typedef enum logic [2:0] {
        INIT, IDLE, RD_EDGE, LAT_EDGE, CLR_EDGE, RD_LVL, LAT_LVL, PUSH
    } state_t;

    state_t             state_q, state_d;
    logic               boot_q, boot_d;
    logic [3:0]         edge_q, edge_d;
    logic [3:0]         level_q, level_d;
    logic [1:0]         addr_q, addr_d;
    logic               cs_q, cs_d;
    logic               wr_n_q, wr_n_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic [EVT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [EVT_W-1:0]   evt_in;
    logic               full, push, drop, pop;
    logic               unused_rd_bits;

    assign unused_rd_bits = ^avm_readdata[31:4];

    // Sequencer; boot_q holds INIT through the first edge so the mask write is seen after reset release.
    always_comb begin
        state_d = state_q;
        boot_d  = 1'b0;
        edge_d  = edge_q;
        level_d = level_q;
        case (state_q)
            INIT:     state_d = boot_q ? INIT : IDLE;
            IDLE:     if (pio_irq && enable) state_d = RD_EDGE;
            RD_EDGE:  state_d = LAT_EDGE;
            LAT_EDGE: begin
                edge_d  = avm_readdata[3:0];
                state_d = CLR_EDGE;
            end
            CLR_EDGE: state_d = RD_LVL;
            RD_LVL:   state_d = LAT_LVL;
            LAT_LVL:  begin
                level_d = avm_readdata[3:0];
                state_d = PUSH;
            end
            PUSH:     state_d = IDLE;
            default:  state_d = INIT;
        endcase

        // Bus registers are loaded from the next state so they line up with the state register.
        addr_d  = 2'd0;
        cs_d    = 1'b0;
        wr_n_d  = 1'b1;
        wdata_d = 32'd0;
        case (state_d)
            INIT: begin
                addr_d  = 2'd2;
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                wdata_d = {28'd0, IRQ_MASK};
            end
            RD_EDGE, LAT_EDGE: addr_d = 2'd3;
            CLR_EDGE: begin
                addr_d  = 2'd3;
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                wdata_d = {28'd0, edge_d};
            end
            default: ;
        endcase
    end

    // Event FIFO: a push into a full FIFO is dropped even when a pop happens in the same cycle.
    always_comb begin
        full = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
               (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
        pop  = valid_q && evt_ready;
        push = 1'b0;
        drop = 1'b0;
        if (state_q == PUSH && edge_q != 4'h0) begin
            push = !full;
            drop = full;
        end
        wr_ptr_d = push ? wr_ptr_q + CNT_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + CNT_W'(1) : rd_ptr_q;
        count_d  = wr_ptr_d - rd_ptr_d;
        valid_d  = (wr_ptr_d != rd_ptr_d);
        ovf_d    = ovf_clr ? 1'b0 : (ovf_q | drop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= INIT;
            boot_q   <= 1'b1;
            edge_q   <= 4'h0;
            level_q  <= 4'h0;
            addr_q   <= 2'd0;
            cs_q     <= 1'b0;
            wr_n_q   <= 1'b1;
            wdata_q  <= 32'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            boot_q   <= boot_d;
            edge_q   <= edge_d;
            level_q  <= level_d;
            addr_q   <= addr_d;
            cs_q     <= cs_d;
            wr_n_q   <= wr_n_d;
            wdata_q  <= wdata_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[IDX_W-1:0]] <= evt_in;
    end

`ifdef BTN_SEQ_TIMESTAMP_EN
    logic [15:0] ts_cnt_q, ts_cnt_d;
    logic [15:0] ts_q, ts_d;

    // Free-running timestamp, captured alongside the edge-capture read.
    always_comb begin
        ts_cnt_d = ts_cnt_q + 16'd1;
        ts_d     = (state_q == LAT_EDGE) ? ts_cnt_q : ts_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt_q <= 16'd0;
            ts_q     <= 16'd0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            ts_q     <= ts_d;
        end
    end

    assign evt_in = {ts_q, level_q, edge_q};
`else
    assign evt_in = {level_q, edge_q};
`endif

    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wr_n_q;
    assign avm_writedata  = wdata_q;
    assign evt_valid      = valid_q;
    assign evt_count      = count_q;
    assign ovf            = ovf_q;
    assign evt_data       = mem_q[rd_ptr_q[IDX_W-1:0]];

endmodule

// File: tb/tb_sockit_ghrd_button_irq_sequencer.sv
// Directed bench for the button IRQ sequencer with a small behavioural PIO model.
// Timestamp checks are compiled in when BTN_SEQ_TIMESTAMP_EN is defined.
module tb_sockit_ghrd_button_irq_sequencer;

`ifdef BTN_SEQ_TIMESTAMP_EN
    localparam int unsigned EVT_W = 24;
`else
    localparam int unsigned EVT_W = 8;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             enable = 1'b1;
    logic             pio_irq;
    logic [1:0]       avm_address;
    logic             avm_chipselect;
    logic             avm_write_n;
    logic [31:0]      avm_writedata;
    logic [31:0]      avm_readdata = 32'd0;
    logic             evt_valid;
    logic             evt_ready = 1'b0;
    logic [EVT_W-1:0] evt_data;
    logic [3:0]       evt_count;
    logic             ovf;
    logic             ovf_clr = 1'b0;

    logic [3:0] edge_cap = 4'h0;
    logic [3:0] mask_r = 4'h0;
    logic [3:0] levels = 4'b1010;
    logic [3:0] inject = 4'h0;
    logic       force_irq = 1'b0;

    int checks = 0;
    int errors = 0;

    sockit_ghrd_button_irq_sequencer #(.IRQ_MASK(4'hF), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pio_irq(pio_irq),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_data(evt_data), .evt_count(evt_count), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // PIO model: registered readdata, write-to-clear edge capture, masked level irq.
    assign pio_irq = (|(edge_cap & mask_r)) | force_irq;

    always @(posedge clk) begin
        if (avm_chipselect && !avm_write_n && avm_address == 2'd2) mask_r <= avm_writedata[3:0];
        edge_cap <= ((avm_chipselect && !avm_write_n && avm_address == 2'd3) ? 4'h0 : edge_cap) | inject;
        case (avm_address)
            2'd0:    avm_readdata <= {28'd0, levels};
            2'd2:    avm_readdata <= {28'd0, mask_r};
            2'd3:    avm_readdata <= {28'd0, edge_cap};
            default: avm_readdata <= 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Latch an edge into the PIO; on return the irq is high in the current cycle (cycle T).
    task automatic raise_edge(input logic [3:0] v);
        inject = v;
        tick();
        inject = 4'h0;
    endtask

    task automatic check_bus(input string tag, input logic [1:0] a, input logic cs,
                             input logic wn, input logic [31:0] wd);
        check(tag, {avm_writedata[27:0], avm_address, avm_chipselect, avm_write_n},
              {wd[27:0], a, cs, wn});
    endtask

`ifdef BTN_SEQ_TIMESTAMP_EN
    logic [15:0] ts_a, ts_b;
    int unsigned gap;
`endif

    initial begin
        #2 reset_n = 1'b0;
        #1;
        check_bus("reset_bus", 2'd0, 1'b0, 1'b1, 32'd0);
        check("reset_fifo", 32'({evt_valid, evt_count, ovf}), 32'h0);
        tick();
        tick();
        #2 reset_n = 1'b1;

        tick();
        check_bus("init_write", 2'd2, 1'b1, 1'b0, 32'hF);
        tick();
        check_bus("init_done_idle", 2'd0, 1'b0, 1'b1, 32'd0);
        check("pio_mask", 32'(mask_r), 32'hF);

        // Basic service: edge 0101, levels 1010.
        raise_edge(4'b0101);
        tick();
        check_bus("rd_edge", 2'd3, 1'b0, 1'b1, 32'd0);
        tick();
        check_bus("lat_edge", 2'd3, 1'b0, 1'b1, 32'd0);
        tick();
        check_bus("clr_edge", 2'd3, 1'b1, 1'b0, 32'h5);
        tick();
        check_bus("rd_lvl", 2'd0, 1'b0, 1'b1, 32'd0);
        check("irq_dropped", 32'(pio_irq), 32'h0);
        tick();
        tick();
        check("valid_before_t7", 32'(evt_valid), 32'h0);
        tick();
        check("evt_valid_t7", 32'(evt_valid), 32'h1);
        check("evt_data_a5", 32'(evt_data[7:0]), 32'hA5);
        check("count_one", 32'(evt_count), 32'h1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("pop_empty", 32'({evt_valid, evt_count}), 32'h0);

        // Spurious interrupt with empty edge capture.
        force_irq = 1'b1;
        tick();
        force_irq = 1'b0;
        tick();
        tick();
        check_bus("spur_clr", 2'd3, 1'b1, 1'b0, 32'h0);
        repeat (4) tick();
        check("spur_no_entry", 32'({evt_valid, evt_count, ovf}), 32'h0);

        // Fill the FIFO with edges 1..8, then overflow with edge 9.
        for (int i = 0; i < 9; i++) begin
            raise_edge(4'(i + 1));
            repeat (7) tick();
            if (i == 7) check("fill_count8", 32'(evt_count), 32'h8);
        end
        check("ovf_set", 32'(ovf), 32'h1);
        check("ovf_count8", 32'(evt_count), 32'h8);
        check("head_kept", 32'(evt_data[7:0]), 32'hA1);

        // Tenth drop coincides with ovf_clr.
        raise_edge(4'hC);
        repeat (6) tick();
        check("ovf_before_clr", 32'(ovf), 32'h1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr_wins", 32'(ovf), 32'h0);
        check("count_after_drop", 32'(evt_count), 32'h8);

        // Drain in order.
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_%0d", i), 32'({evt_valid, evt_data[7:0]}), 32'({1'b1, 4'hA, 4'(i + 1)}));
            tick();
        end
        evt_ready = 1'b0;
        check("drained", 32'({evt_valid, evt_count}), 32'h0);

        // Enable gating with irq held high.
        enable = 1'b0;
        raise_edge(4'b1000);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("en0_idle_%0d", i), 32'({avm_chipselect, avm_address, avm_write_n}), 32'h1);
            tick();
        end
        enable = 1'b1;
        tick();
        check_bus("en1_rd_edge", 2'd3, 1'b0, 1'b1, 32'd0);
        repeat (6) tick();
        check("en1_event", 32'({evt_valid, evt_data[7:0]}), 32'h1A8);

        // Reset during CLR_EDGE with one entry still queued.
        raise_edge(4'b0011);
        repeat (3) tick();
        check_bus("pre_rst_clr", 2'd3, 1'b1, 1'b0, 32'h3);
        check("pre_rst_count", 32'(evt_count), 32'h1);
        reset_n = 1'b0;
        #1;
        check_bus("rst_abort_bus", 2'd0, 1'b0, 1'b1, 32'd0);
        check("rst_abort_fifo", 32'({evt_valid, evt_count, ovf}), 32'h0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        check_bus("reinit_write", 2'd2, 1'b1, 1'b0, 32'hF);
        tick();
        check_bus("reinit_idle", 2'd0, 1'b0, 1'b1, 32'd0);
        repeat (3) tick();
        check_bus("pending_clr", 2'd3, 1'b1, 1'b0, 32'h3);
        repeat (4) tick();
        check("pending_event", 32'({evt_valid, evt_count, evt_data[7:0]}), 32'h1_1A3);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;

`ifdef BTN_SEQ_TIMESTAMP_EN
        // Two events with LAT_EDGE 20 cycles apart.
        raise_edge(4'h1);
        repeat (19) tick();
        raise_edge(4'h2);
        repeat (7) tick();
        check("ts_count2", 32'(evt_count), 32'h2);
        ts_a = evt_data[23:8];
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        ts_b = evt_data[23:8];
        check("ts_delta20", 32'(ts_b - ts_a), 32'd20);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        // Counter now reads ts_b + 7; place the next LAT_EDGE at 16'hFFF8.
        gap = 32'(16'hFFF8 - (ts_b + 16'd10));
        repeat (gap) tick();
        raise_edge(4'h4);
        repeat (19) tick();
        raise_edge(4'h8);
        repeat (7) tick();
        ts_a = evt_data[23:8];
        check("ts_near_wrap", 32'(ts_a), 32'hFFF8);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        ts_b = evt_data[23:8];
        check("ts_wrapped", 32'(ts_b), 32'h000C);
        check("ts_wrap_delta20", 32'(ts_b - ts_a), 32'd20);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sockit_ghrd_button_irq_sequencer.md
# sockit_ghrd_button_irq_sequencer

Hardware servicer for the 4-bit button PIO. It acts as an Avalon-MM master on the PIO slave port: it programs the interrupt mask after reset, and on each PIO `irq` it reads and clears the edge-capture register and samples the live button levels. Each serviced interrupt becomes one event record in an internal FIFO, drained by a ready/valid consumer (HPS bridge CSR or fabric logic), so no CPU interrupt handler is needed.

## Interface
- `IRQ_MASK`, 4'hF: value written to PIO address 2 during init.
- `FIFO_DEPTH`, 8: event FIFO entries; power of 2, 2..64.
- `clk` input 1: clock.
- `reset_n` input 1: reset, asynchronous, active-low.
- `enable` input 1: when 0, no new interrupt service starts. Init and any in-progress service still complete.
- `pio_irq` input 1: level interrupt from the PIO.
- `avm_address` output 2: PIO register address.
- `avm_chipselect` output 1: PIO chipselect, used for writes only.
- `avm_write_n` output 1: PIO write strobe, active-low.
- `avm_writedata` output 32: PIO write data.
- `avm_readdata` input 32: PIO registered read data. It reflects the address driven in the previous cycle.
- `evt_valid` output 1: FIFO not empty.
- `evt_ready` input 1: consumer pop.
- `evt_data` output W: head entry. W=8 is `{level[3:0], edge[3:0]}`. W=24 is `{ts[15:0], level, edge}` (see Configuration).
- `evt_count` output clog2(FIFO_DEPTH)+1: current occupancy.
- `ovf` output 1: sticky, set when an event is dropped.
- `ovf_clr` input 1: synchronous clear of `ovf`.

## Operation
- FSM states: INIT, IDLE, RD_EDGE, LAT_EDGE, CLR_EDGE, RD_LVL, LAT_LVL, PUSH.
- Reset enters INIT.
- INIT (1 cycle): address=2, chipselect=1, write_n=0, writedata={28'b0, IRQ_MASK}. Next state IDLE.
- IDLE: if `pio_irq & enable`, go to RD_EDGE; otherwise stay in IDLE.
- RD_EDGE: address=3, chipselect=0, write_n=1.
- LAT_EDGE: edge_r <= avm_readdata[3:0]. Address stays 3.
- CLR_EDGE: address=3, chipselect=1, write_n=0, writedata={28'b0, edge_r}. The PIO clears the whole edge-capture register.
- RD_LVL: address=0.
- LAT_LVL: level_r <= avm_readdata[3:0].
- PUSH: write the entry if edge_r != 0 and the FIFO is not full. If edge_r == 0 (spurious irq), do not write. If the FIFO is full, drop the entry and set `ovf`. Next state is always IDLE.
- Bus idle defaults, in every state not listed above: address=0, chipselect=0, write_n=1, writedata=0.
- FIFO: circular buffer with read/write pointers one bit wider than the index.
  - Pointers wrap modulo FIFO_DEPTH.
  - Full when the MSBs differ and the index bits are equal.
  - A pop occurs when `evt_valid & evt_ready`.
  - `evt_data` is the head entry, combinational from the read pointer.
- Push and pop in the same cycle: a push into a full FIFO is dropped even if a pop occurs that cycle. Count changes by +1, 0, or -1 accordingly.
- `ovf`: `ovf_clr` wins over a same-cycle drop; `ovf` stays 0 that cycle.
- Edges arriving in the PIO after the LAT_EDGE sample and before the CLR_EDGE write are lost. This is an accepted 1-cycle window inherent to the PIO.
- `enable` deasserted mid-service does not abort the sequence.

## Timing
- Reset values:
  - Bus outputs: address 0, chipselect 0, write_n 1, writedata 0.
  - evt_valid 0, evt_count 0, ovf 0.
  - FSM in INIT; FIFO pointers 0.
- INIT write occurs in the first clock after reset deassertion.
- `pio_irq` sampled high in IDLE at cycle T:
  - RD_EDGE at T+1, LAT_EDGE at T+2, CLR_EDGE at T+3, RD_LVL at T+4, LAT_LVL at T+5, PUSH at T+6.
  - `evt_valid` high at T+7 (FIFO previously empty).
- PIO `irq` drops at T+4 after the clear. IDLE re-samples at T+7, so a stale irq never retriggers.
- Service throughput: at most 1 event per 7 cycles.
- Pop latency: `evt_data` advances in the cycle after the pop edge.
- Reset mid-service: asynchronous abort. The FIFO is emptied and INIT re-runs. The PIO edge-capture contents are left as-is and are serviced once the PIO `irq` is seen in IDLE.

## Configuration
- `BTN_SEQ_TIMESTAMP_EN` defined:
  - A 16-bit free-running counter is added. It resets to 0, increments every clk, and wraps 16'hFFFF -> 0.
  - The counter is sampled into ts_r in LAT_EDGE.
  - W=24, with `evt_data[23:8]` = ts_r.
- Macro undefined: no counter, W=8.

## Test plan
- Reset release: cycle 1 shows address=2, chipselect=1, write_n=0, writedata=32'hF. Bus returns to idle defaults in cycle 2.
- Model PIO with edge_capture=4'b0101, levels=4'b1010, irq high:
  - Writedata 32'h5 to address 3 at T+3.
  - `evt_valid` at T+7 with `evt_data`=8'hA5.
  - After one pop, `evt_valid`=0 and `evt_count`=0.
- Spurious irq with edge_capture=0: the full sequence runs, no FIFO entry is written, `ovf` stays 0.
- FIFO_DEPTH=8, `evt_ready`=0, 9 interrupts:
  - After 8, `evt_count`=8.
  - The 9th sets `ovf`; `evt_count` stays 8.
  - `ovf_clr` asserted in the same cycle as a 10th drop leaves `ovf`=0.
- `enable`=0 with irq held high: no bus activity after INIT. Raising `enable` starts RD_EDGE on the next cycle.
- Reset asserted during CLR_EDGE: outputs immediately return to their reset values and `evt_count`=0. INIT repeats, then the pending irq is serviced.
- With `BTN_SEQ_TIMESTAMP_EN` defined: two events whose LAT_EDGE cycles are 20 apart have `ts` fields differing by 20. Also check a case where the counter wraps between the two events.
